// File: rtl/mp_fb_capture.sv
// Feedback-path snapshot capture: arms, waits for a trigger, stores DEPTH
// complex samples from a 4-lane ADC stream into four interleaved banks, and
// serves word reads through a fixed two-stage pipeline once capture is over.
module mp_fb_capture #(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH) + 2
) (
    input  logic          JESD_clk_i,
    input  logic          reset_i,
    input  logic [127:0]  adc_i,
    input  logic          adc_valid_i,
    input  logic          arm_i,
    input  logic          trig_i,
    input  logic          abort_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [31:0]   rd_data_o,
    output logic          rd_valid_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          ovf_o
);

    localparam int ROWS = DEPTH / 4;
    localparam int RW   = $clog2(ROWS);
    localparam int IW   = $clog2(DEPTH);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

    logic [1:0]       state;
    logic [RW-1:0]    wcnt;
    logic [31:0]      mem [4][ROWS];
    logic [3:0][31:0] smp;
    logic             arm_ok;
    logic             abort_ok;
    logic             wr_en;
    logic             wr_ovf;
    logic             vld_p1;
    logic             blank_p1;
    logic [IW-1:0]    idx_p1;
    logic             addr_unused;

    // Sample k: I = {lane0 byte k, lane1 byte k}, Q = {lane2 byte k, lane3 byte k}.
    function automatic logic [31:0] unpack_sample(input logic [127:0] w, input int k);
        return {w[8*k +: 8], w[32+8*k +: 8], w[64+8*k +: 8], w[96+8*k +: 8]};
    endfunction

    // A 16-bit component is out of range when its top two bits disagree.
    function automatic logic out_of_range(input logic [31:0] s);
        return (s[31] ^ s[30]) | (s[15] ^ s[14]);
    endfunction

    assign busy_o      = (state == ST_ARMED) || (state == ST_CAPTURE);
    assign done_o      = (state == ST_DONE);
    assign addr_unused = ^rd_addr_i[1:0];

    // Qualify control pulses by state, decide whether this beat is stored, and unpack the lanes.
    always_comb begin
        arm_ok   = arm_i && ((state == ST_IDLE) || (state == ST_DONE));
        abort_ok = abort_i && busy_o;
        wr_en    = adc_valid_i && !abort_ok &&
                   (((state == ST_ARMED) && trig_i) || (state == ST_CAPTURE));
        wr_ovf   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            smp[k] = unpack_sample(adc_i, k);
            wr_ovf = wr_ovf | out_of_range(smp[k]);
        end
    end

    // Capture sequencer: abort wins over everything, the trigger beat is row 0, the last row ends capture.
    always_ff @(posedge JESD_clk_i or posedge reset_i) begin
        if (reset_i) begin
            state <= ST_IDLE;
            wcnt  <= '0;
            ovf_o <= 1'b0;
        end else begin
            if (abort_ok) begin
                state <= ST_IDLE;
            end else if (arm_ok) begin
                state <= ST_ARMED;
                wcnt  <= '0;
            end else if (wr_en) begin
                if (state == ST_ARMED) begin
                    state <= ST_CAPTURE;
                end else if (wcnt == LAST_ROW) begin
                    state <= ST_DONE;
                end
                wcnt <= wcnt + RW'(1);
            end
            if (arm_ok) begin
                ovf_o <= 1'b0;
            end else if (wr_en && wr_ovf) begin
                ovf_o <= 1'b1;
            end
        end
    end

    // Each stored beat fills one row across all four banks; bank = sample index [1:0].
    always_ff @(posedge JESD_clk_i) begin
        if (wr_en) begin
            for (int k = 0; k < 4; k++) begin
                mem[k][wcnt] <= smp[k];
            end
        end
    end

    // Read stage 1 control: remember the request and whether it was issued while busy.
    always_ff @(posedge JESD_clk_i or posedge reset_i) begin
        if (reset_i) begin
            vld_p1   <= 1'b0;
            blank_p1 <= 1'b0;
        end else begin
            vld_p1   <= rd_en_i;
            blank_p1 <= busy_o;
        end
    end

    // Read stage 1 data: word index of the requested sample.
    always_ff @(posedge JESD_clk_i) begin
        idx_p1 <= rd_addr_i[IW+1:2];
    end

    // Read stage 2: bank/row lookup, zero when idle or when the request was issued during capture.
    always_ff @(posedge JESD_clk_i or posedge reset_i) begin
        if (reset_i) begin
            rd_valid_o <= 1'b0;
            rd_data_o  <= 32'h0;
        end else begin
            rd_valid_o <= vld_p1;
            rd_data_o  <= (vld_p1 && !blank_p1) ? mem[idx_p1[1:0]][idx_p1[IW-1:2]] : 32'h0;
        end
    end

endmodule

// File: tb/tb_mp_fb_capture.sv
// Randomized bench for mp_fb_capture (DEPTH=16): a sample-array model tracks
// what should be stored, and a two-deep queue of expected read results is
// compared against the read port every cycle.
module tb_mp_fb_capture;

    localparam int DEPTH = 16;
    localparam int AW    = 6;

    logic          JESD_clk_i = 1'b0;
    logic          reset_i;
    logic [127:0]  adc_i;
    logic          adc_valid_i;
    logic          arm_i;
    logic          trig_i;
    logic          abort_i;
    logic          rd_en_i;
    logic [AW-1:0] rd_addr_i;
    logic [31:0]   rd_data_o;
    logic          rd_valid_o;
    logic          busy_o;
    logic          done_o;
    logic          ovf_o;

    typedef struct {
        logic        v;
        logic [31:0] d;
    } rd_t;

    rd_t         pipe[$];
    logic [31:0] exp_mem [DEPTH];
    bit          m_busy;
    bit          m_ovf;
    int          n_checks;
    int          n_errors;
    int          vcount;

    mp_fb_capture #(.DEPTH(DEPTH), .AW(AW)) dut (
        .JESD_clk_i  (JESD_clk_i),
        .reset_i     (reset_i),
        .adc_i       (adc_i),
        .adc_valid_i (adc_valid_i),
        .arm_i       (arm_i),
        .trig_i      (trig_i),
        .abort_i     (abort_i),
        .rd_en_i     (rd_en_i),
        .rd_addr_i   (rd_addr_i),
        .rd_data_o   (rd_data_o),
        .rd_valid_o  (rd_valid_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .ovf_o       (ovf_o)
    );

    initial forever #5 JESD_clk_i = ~JESD_clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // In-range sample: each 16-bit half is a sign-extended 15-bit value.
    function automatic logic [31:0] rand_sample();
        logic [31:0] r;
        r = $urandom;
        return {r[30], r[30:16], r[14], r[14:0]};
    endfunction

    function automatic bit sample_ovf(input logic [31:0] s);
        return (s[31] != s[30]) || (s[15] != s[14]);
    endfunction

    // Scatter four {I,Q} samples onto the lane bytes.
    function automatic logic [127:0] pack(input logic [3:0][31:0] s);
        logic [127:0] w;
        w = '0;
        for (int k = 0; k < 4; k++) begin
            w[8*k +: 8]      = s[k][31:24];
            w[32 + 8*k +: 8] = s[k][23:16];
            w[64 + 8*k +: 8] = s[k][15:8];
            w[96 + 8*k +: 8] = s[k][7:0];
        end
        return w;
    endfunction

    // One clock: log the read issued this cycle, then check the one issued a cycle earlier.
    task automatic tick();
        rd_t e;
        e.v = rd_en_i;
        e.d = (rd_en_i && !m_busy) ? exp_mem[rd_addr_i[AW-1:2]] : 32'h0;
        pipe.push_back(e);
        @(posedge JESD_clk_i);
        #1;
        if (rd_valid_o) vcount++;
        if (pipe.size() == 2) begin
            e = pipe.pop_front();
            chk("rd_valid", rd_valid_o, e.v);
            chk("rd_data", rd_data_o, e.d);
        end
    endtask

    task automatic capture(input int gap, input int bad_pos, input bit abort_last, input bit rd_gap);
        logic [3:0][31:0] s;
        bit               last_abort;
        arm_i       = 1'b1;
        trig_i      = 1'b1;
        adc_valid_i = 1'b1;
        adc_i       = {$urandom, $urandom, $urandom, $urandom};
        tick();
        arm_i       = 1'b0;
        adc_valid_i = 1'b0;
        m_busy      = 1'b1;
        m_ovf       = 1'b0;
        chk("busy_armed", busy_o, 1);
        chk("done_armed", done_o, 0);
        chk("ovf_cleared", ovf_o, 0);
        tick();
        chk("busy_trig_no_valid", busy_o, 1);
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 4; k++) begin
                s[k] = rand_sample();
                if (4*b + k == bad_pos) s[k][31:16] = 16'h4000;
            end
            last_abort  = abort_last && (b == 3);
            adc_i       = pack(s);
            adc_valid_i = 1'b1;
            trig_i      = (b == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            abort_i     = last_abort;
            tick();
            adc_valid_i = 1'b0;
            abort_i     = 1'b0;
            if (!last_abort) begin
                for (int k = 0; k < 4; k++) begin
                    exp_mem[4*b + k] = s[k];
                    if (sample_ovf(s[k])) m_ovf = 1'b1;
                end
            end
            if (b < 3) begin
                chk("done_early", done_o, 0);
                chk("busy_capture", busy_o, 1);
                for (int g = 0; g < gap; g++) begin
                    rd_en_i   = rd_gap;
                    rd_addr_i = AW'($urandom);
                    adc_i     = {$urandom, $urandom, $urandom, $urandom};
                    trig_i    = 1'($urandom_range(0, 1));
                    tick();
                    chk("done_gap", done_o, 0);
                end
                rd_en_i = 1'b0;
            end
        end
        trig_i = 1'b0;
        m_busy = 1'b0;
        if (abort_last) begin
            chk("busy_abort", busy_o, 0);
            chk("done_abort", done_o, 0);
            tick();
            chk("done_after_abort", done_o, 0);
            chk("busy_after_abort", busy_o, 0);
        end else begin
            chk("done_final", done_o, 1);
            chk("busy_final", busy_o, 0);
            chk("ovf_final", ovf_o, m_ovf);
        end
    endtask

    task automatic burst_read();
        tick();
        vcount = 0;
        for (int i = 0; i < DEPTH; i++) begin
            rd_en_i   = 1'b1;
            rd_addr_i = AW'(4*i);
            tick();
        end
        rd_en_i = 1'b0;
        tick();
        tick();
        chk("burst_valid_count", vcount, DEPTH);
    endtask

    task automatic rand_reads(input int n);
        for (int i = 0; i < n; i++) begin
            rd_en_i   = 1'($urandom_range(0, 1));
            rd_addr_i = AW'($urandom);
            tick();
        end
        rd_en_i = 1'b0;
        tick();
        tick();
    endtask

    task automatic reset_mid_capture();
        logic [3:0][31:0] s;
        arm_i = 1'b1;
        tick();
        arm_i  = 1'b0;
        m_busy = 1'b1;
        for (int k = 0; k < 4; k++) s[k] = rand_sample();
        s[0][31:16] = 16'h4000;
        adc_i       = pack(s);
        adc_valid_i = 1'b1;
        trig_i      = 1'b1;
        rd_en_i     = 1'b1;
        rd_addr_i   = AW'($urandom);
        tick();
        adc_valid_i = 1'b0;
        trig_i      = 1'b0;
        tick();
        chk("pre_reset_ovf", ovf_o, 1);
        chk("pre_reset_busy", busy_o, 1);
        chk("pre_reset_rd_valid", rd_valid_o, 1);
        #2 reset_i = 1'b1;
        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_ovf", ovf_o, 0);
        chk("rst_rd_valid", rd_valid_o, 0);
        chk("rst_rd_data", rd_data_o, 0);
        pipe.delete();
        rd_en_i = 1'b0;
        m_busy  = 1'b0;
        #1 reset_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_reset_rd_valid", rd_valid_o, 0);
            chk("post_reset_busy", busy_o, 0);
        end
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        vcount      = 0;
        m_busy      = 1'b0;
        m_ovf       = 1'b0;
        reset_i     = 1'b1;
        arm_i       = 1'b0;
        trig_i      = 1'b0;
        abort_i     = 1'b0;
        adc_valid_i = 1'b0;
        adc_i       = '0;
        rd_en_i     = 1'b0;
        rd_addr_i   = '0;
        repeat (2) @(posedge JESD_clk_i);
        #1;
        chk("reset_busy", busy_o, 0);
        chk("reset_done", done_o, 0);
        chk("reset_ovf", ovf_o, 0);
        chk("reset_rd_valid", rd_valid_o, 0);
        chk("reset_rd_data", rd_data_o, 0);

        // Arm on the very first edge after reset release, then abort back to idle.
        arm_i   = 1'b1;
        reset_i = 1'b0;
        tick();
        arm_i  = 1'b0;
        m_busy = 1'b1;
        chk("arm_after_reset", busy_o, 1);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        m_busy  = 1'b0;
        chk("abort_armed_busy", busy_o, 0);
        chk("abort_armed_done", done_o, 0);

        capture(0, -1, 1'b0, 1'b0);
        burst_read();
        rand_reads(24);

        capture(3, -1, 1'b0, 1'b1);
        burst_read();
        rand_reads(32);

        capture(1, int'($urandom_range(0, DEPTH-1)), 1'b0, 1'b1);
        chk("ovf_set", ovf_o, 1);
        rand_reads(16);
        chk("ovf_sticky", ovf_o, 1);

        capture(0, -1, 1'b1, 1'b0);

        reset_mid_capture();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
